adc_serial_emulator: RTL and testbench

- Synthesizable transmitter end of the serial ADC interface: emulates the 8-channel simultaneous-sampling ADC that the ADC controller reads.
- Responds to convst/cs/sclk from the ADC controller and drives busy plus two serial data lines (A: channels 0-3, B: channels 4-7).
- Used for on-board loopback self-test and as the ADC model in system simulation.
- Channel values come from a parallel input bus, latched at conversion start.

---
 rtl/adc_serial_emulator.sv | 228 ++++++++++++++++++++++
 tb/tb_adc_serial_emulator.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_serial_emulator.sv
// adc_serial_emulator: transmitter side of an 8-channel simultaneous-sampling
// serial ADC. Latches parallel channel words on convst, holds busy for T_BUSY
// cycles, then shifts the words out MSB-first on two data lines while the
// controller clocks sclk with chip select low.
module adc_serial_emulator #(
  parameter int W_DATA = 18,
  parameter int N_CHAN = 8,
  parameter int T_BUSY = 85,
  parameter int TX_LEN = W_DATA * N_CHAN / 2
) (
  input  logic                       clk_in,
  input  logic                       reset_in,
  input  logic [N_CHAN*W_DATA-1:0]   chan_data_in,
  input  logic                       adc_convst_in,
  input  logic                       adc_n_cs_in,
  input  logic                       adc_sclk_in,
  output logic                       adc_busy_out,
  output logic                       adc_data_a_out,
  output logic                       adc_data_b_out,
  output logic                       frame_done_out
);

  localparam int W_BCNT = $clog2(T_BUSY + 1);
  localparam int W_BIT  = $clog2(TX_LEN + 1);
  localparam int N_HALF = N_CHAN / 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_READY   = 2'd2,
    S_SHIFT   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_convst_d;
  logic               r_n_cs_d;
  logic               r_sclk_d;
  logic [TX_LEN-1:0]  r_sr_a;
  logic [TX_LEN-1:0]  r_sr_b;
  logic [W_BCNT-1:0]  r_busy_cnt;
  logic [W_BIT-1:0]   r_bit_cnt;
  logic               r_busy;
  logic               r_data_a;
  logic               r_data_b;
  logic               r_frame_done;

  logic [TX_LEN-1:0]  w_sr_a_nxt;
  logic [TX_LEN-1:0]  w_sr_b_nxt;
  logic [W_BCNT-1:0]  w_busy_cnt_nxt;
  logic [W_BIT-1:0]   w_bit_cnt_nxt;
  logic               w_busy_nxt;
  logic               w_data_a_nxt;
  logic               w_data_b_nxt;
  logic               w_frame_done_nxt;
  logic [TX_LEN-1:0]  w_load_a;
  logic [TX_LEN-1:0]  w_load_b;
  logic [W_BIT-1:0]   w_bit_inc;

  // Inputs share our clock, so one register stage is enough for edge detection.
  logic w_convst_rise;
  logic w_cs_fall;
  logic w_cs_rise;
  logic w_sclk_fall;
  logic w_shift_edge;
  logic w_last_edge;

  assign w_convst_rise = adc_convst_in & ~r_convst_d;
  assign w_cs_fall     = ~adc_n_cs_in & r_n_cs_d;
  assign w_cs_rise     = adc_n_cs_in & ~r_n_cs_d;
  assign w_sclk_fall   = ~adc_sclk_in & r_sclk_d;
  assign w_shift_edge  = w_sclk_fall & ~adc_n_cs_in;
  assign w_bit_inc     = r_bit_cnt + W_BIT'(1);
  assign w_last_edge   = (w_bit_inc == W_BIT'(TX_LEN));

  // Pack channel words so the lowest channel of each line sits in the MSBs.
  always_comb begin
    w_load_a = '0;
    w_load_b = '0;
    for (int k = 0; k < N_HALF; k++) begin
      w_load_a[TX_LEN-1-k*W_DATA -: W_DATA] = chan_data_in[k*W_DATA +: W_DATA];
      w_load_b[TX_LEN-1-k*W_DATA -: W_DATA] = chan_data_in[(k+N_HALF)*W_DATA +: W_DATA];
    end
  end

  // State register plus input edge-detect flops.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state    <= S_IDLE;
      r_convst_d <= 1'b0;
      r_n_cs_d   <= 1'b0;
      r_sclk_d   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_convst_d <= adc_convst_in;
      r_n_cs_d   <= adc_n_cs_in;
      r_sclk_d   <= adc_sclk_in;
    end
  end

  // Next-state logic; abort on cs rising outranks a coincident sclk fall.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_convst_rise) w_state_nxt = S_CONVERT;
        else               w_state_nxt = S_IDLE;
      end
      S_CONVERT: begin
        if (r_busy_cnt == W_BCNT'(0)) w_state_nxt = S_READY;
        else                          w_state_nxt = S_CONVERT;
      end
      S_READY: begin
        if (w_cs_fall)          w_state_nxt = S_SHIFT;
        else if (w_convst_rise) w_state_nxt = S_CONVERT;
        else                    w_state_nxt = S_READY;
      end
      S_SHIFT: begin
        if (w_cs_rise)                        w_state_nxt = S_IDLE;
        else if (w_shift_edge && w_last_edge) w_state_nxt = S_IDLE;
        else                                  w_state_nxt = S_SHIFT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the datapath and the registered outputs.
  always_comb begin
    w_sr_a_nxt       = r_sr_a;
    w_sr_b_nxt       = r_sr_b;
    w_busy_cnt_nxt   = r_busy_cnt;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_busy_nxt       = r_busy;
    w_data_a_nxt     = r_data_a;
    w_data_b_nxt     = r_data_b;
    w_frame_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_convst_rise) begin
          w_sr_a_nxt     = w_load_a;
          w_sr_b_nxt     = w_load_b;
          w_busy_nxt     = 1'b1;
          w_busy_cnt_nxt = W_BCNT'(T_BUSY - 1);
        end else begin
          w_data_a_nxt = 1'b0;
          w_data_b_nxt = 1'b0;
        end
      end
      S_CONVERT: begin
        if (r_busy_cnt == W_BCNT'(0)) begin
          w_busy_nxt = 1'b0;
        end else begin
          w_busy_cnt_nxt = r_busy_cnt - W_BCNT'(1);
        end
      end
      S_READY: begin
        // A coincident sclk fall is deliberately not acted on: MSB only.
        if (w_cs_fall) begin
          w_data_a_nxt  = r_sr_a[TX_LEN-1];
          w_data_b_nxt  = r_sr_b[TX_LEN-1];
          w_bit_cnt_nxt = W_BIT'(0);
        end else if (w_convst_rise) begin
          w_sr_a_nxt     = w_load_a;
          w_sr_b_nxt     = w_load_b;
          w_busy_nxt     = 1'b1;
          w_busy_cnt_nxt = W_BCNT'(T_BUSY - 1);
        end else begin
          w_data_a_nxt = 1'b0;
          w_data_b_nxt = 1'b0;
        end
      end
      S_SHIFT: begin
        if (w_cs_rise) begin
          w_data_a_nxt = 1'b0;
          w_data_b_nxt = 1'b0;
        end else if (w_shift_edge) begin
          w_bit_cnt_nxt = w_bit_inc;
          if (w_last_edge) begin
            w_data_a_nxt     = 1'b0;
            w_data_b_nxt     = 1'b0;
            w_frame_done_nxt = 1'b1;
          end else begin
            w_sr_a_nxt   = {r_sr_a[TX_LEN-2:0], 1'b0};
            w_sr_b_nxt   = {r_sr_b[TX_LEN-2:0], 1'b0};
            w_data_a_nxt = r_sr_a[TX_LEN-2];
            w_data_b_nxt = r_sr_b[TX_LEN-2];
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt;
        end
      end
      default: begin
        w_busy_nxt   = 1'b0;
        w_data_a_nxt = 1'b0;
        w_data_b_nxt = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset clears everything.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_sr_a       <= '0;
      r_sr_b       <= '0;
      r_busy_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_busy       <= 1'b0;
      r_data_a     <= 1'b0;
      r_data_b     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_sr_a       <= w_sr_a_nxt;
      r_sr_b       <= w_sr_b_nxt;
      r_busy_cnt   <= w_busy_cnt_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_busy       <= w_busy_nxt;
      r_data_a     <= w_data_a_nxt;
      r_data_b     <= w_data_b_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign adc_busy_out   = r_busy;
  assign adc_data_a_out = r_data_a;
  assign adc_data_b_out = r_data_b;
  assign frame_done_out = r_frame_done;

endmodule

// File: tb/tb_adc_serial_emulator.sv
// Directed, table-driven bench for adc_serial_emulator.
module tb_adc_serial_emulator;

  logic         clk;
  logic         reset;
  logic [143:0] chan;
  logic         convst;
  logic         n_cs;
  logic         sclk;
  logic         busy;
  logic         da;
  logic         db;
  logic         fd;

  int n_vec;
  int n_err;
  int fd_cnt;

  typedef struct {
    logic [7:0][17:0] ch;
    logic [71:0]      ea;
    logic [71:0]      eb;
    bit               simul;
  } vec_t;

  vec_t vecs[4];

  adc_serial_emulator dut (
    .clk_in         (clk),
    .reset_in       (reset),
    .chan_data_in   (chan),
    .adc_convst_in  (convst),
    .adc_n_cs_in    (n_cs),
    .adc_sclk_in    (sclk),
    .adc_busy_out   (busy),
    .adc_data_a_out (da),
    .adc_data_b_out (db),
    .frame_done_out (fd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count frame_done pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (fd === 1'b1) fd_cnt <= fd_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Pulse convst and measure the busy window; optional retrigger while busy.
  task automatic do_conv(input bit retrig);
    int cnt;
    convst = 1'b1;
    tick();
    convst = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      if (retrig && cnt == 10) convst = 1'b1;
      if (retrig && cnt == 12) convst = 1'b0;
      tick();
    end
    chk("busy_len", 72'(cnt), 72'd85);
  endtask

  // Clock n sclk periods (rise then fall) without capturing.
  task automatic shift_bits(input int n);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b1; tick(); tick();
      sclk = 1'b0; tick(); tick();
    end
  endtask

  // Full 72-bit read, capturing on sclk rise like the controller.
  task automatic read_frame(input vec_t v, input string nm);
    logic [71:0] ga;
    logic [71:0] gb;
    int fd0;
    ga = '0;
    gb = '0;
    fd0 = fd_cnt;
    if (v.simul) begin
      sclk = 1'b1; tick(); tick();
    end
    n_cs = 1'b0;
    sclk = 1'b0;
    tick(); tick();
    for (int i = 0; i < 72; i++) begin
      ga = {ga[70:0], da};
      gb = {gb[70:0], db};
      sclk = 1'b1; tick(); tick();
      sclk = 1'b0; tick(); tick();
    end
    chk({nm, "_a"}, ga, v.ea);
    chk({nm, "_b"}, gb, v.eb);
    chk({nm, "_done"}, 72'(fd_cnt - fd0), 72'd1);
    chk({nm, "_end0"}, 72'({da, db}), 72'd0);
    shift_bits(2);
    chk({nm, "_idle0"}, 72'({da, db, fd}), 72'd0);
    n_cs = 1'b1;
    tick(); tick();
  endtask

  initial begin
    vec_t va;
    int fd0;
    n_vec = 0; n_err = 0; fd_cnt = 0;
    reset = 1'b1; convst = 1'b0; n_cs = 1'b1; sclk = 1'b0; chan = '0;

    vecs[0].ch = '0; vecs[0].ch[3] = 18'h09999; vecs[0].ch[4] = 18'h3FFFF;
    vecs[0].ea = 72'h000000000000009999; vecs[0].eb = 72'hFFFFC0000000000000;
    vecs[0].simul = 1'b0;
    vecs[1].ch = '0; vecs[1].ch[0] = 18'h00001; vecs[1].ch[7] = 18'h20000;
    vecs[1].ea = 72'h000040000000000000; vecs[1].eb = 72'h000000000000020000;
    vecs[1].simul = 1'b0;
    vecs[2].ch = '0; vecs[2].ch[1] = 18'h12345; vecs[2].ch[6] = 18'h3C3C3;
    vecs[2].ea = 72'h000012345000000000; vecs[2].eb = 72'h000000000F0F0C0000;
    vecs[2].simul = 1'b0;
    vecs[3] = vecs[0];
    vecs[3].simul = 1'b1;

    // Reset held while inputs toggle.
    for (int i = 0; i < 8; i++) begin
      convst = i[0];
      n_cs   = ~i[1];
      sclk   = i[0] ^ i[2];
      chan   = {$urandom, $urandom, $urandom, $urandom, $urandom};
      tick();
      chk("reset_out", 72'({busy, da, db, fd}), 72'd0);
    end
    convst = 1'b0; n_cs = 1'b1; sclk = 1'b0;
    tick();
    reset = 1'b0;
    tick(); tick();

    // Busy window with a retrigger during conversion.
    chan = '0;
    do_conv(1'b1);
    tick(); tick();
    chk("busy_stays_low", 72'(busy), 72'd0);

    // Table-driven frames.
    for (int v = 0; v < 4; v++) begin
      chan = vecs[v].ch;
      do_conv(1'b0);
      read_frame(vecs[v], $sformatf("vec%0d", v));
    end

    // Abort after 20 bits.
    chan = {144{1'b1}};
    do_conv(1'b0);
    fd0 = fd_cnt;
    n_cs = 1'b0; tick(); tick();
    shift_bits(20);
    chk("abort_pre", 72'({da, db}), 72'd3);
    n_cs = 1'b1; tick(); tick();
    chk("abort_data0", 72'({da, db}), 72'd0);
    n_cs = 1'b0; tick(); tick();
    shift_bits(1);
    chk("abort_idle", 72'({da, db}), 72'd0);
    chk("abort_nodone", 72'(fd_cnt - fd0), 72'd0);
    n_cs = 1'b1; tick(); tick();
    chan = vecs[0].ch;
    do_conv(1'b0);
    read_frame(vecs[0], "after_abort");

    // Reconvert in READY: second word wins.
    chan = '0; chan[17:0] = 18'h00001;
    do_conv(1'b0);
    chan[17:0] = 18'h00002;
    do_conv(1'b0);
    va.ch = '0;
    va.ea = 72'h000080000000000000;
    va.eb = 72'h0;
    va.simul = 1'b0;
    read_frame(va, "reconv");

    // Reset at bit 40 of a frame.
    chan = {144{1'b1}};
    do_conv(1'b0);
    n_cs = 1'b0; tick(); tick();
    shift_bits(40);
    chk("rst40_pre", 72'({da, db}), 72'd3);
    reset = 1'b1;
    tick();
    chk("rst40_out", 72'({busy, da, db, fd}), 72'd0);
    reset = 1'b0; n_cs = 1'b1; sclk = 1'b0;
    tick(); tick();
    chan = vecs[2].ch;
    do_conv(1'b0);
    read_frame(vecs[2], "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
